key_scan_debounce: RTL and testbench
====================================

Name: key_scan_debounce

Overview:
- Front end for the segment-display path: turns raw, bouncing push-button inputs into the clean one-hot `Key[13:0]` vector the display decoder consumes.
- Also produces a binary key code and one-cycle press/release strobes for future counters and menu logic.
- Each key input is synchronised, debounced as a vector, resolved to a single winning key (lowest index) and held until release.

Parameters:
N_KEYS, 14, number of button inputs; the one-hot output width equals N_KEYS.
DEBOUNCE_CYCLES, 1000000, number of consecutive stable clocks required to accept a press or a release (20 ms at 50 MHz); legal range ≥2.
RAW_ACTIVE_LOW, 1, 1 means a pressed button reads 0 on key_raw; 0 means a pressed button reads 1.

Ports:
clk_in  input  1  system clock; all logic is on its rising edge.
rst_n  input  1  asynchronous active-low reset.
key_raw  input  N_KEYS  raw button pins, asynchronous to clk_in.
Key  output  N_KEYS  one-hot debounced key; bit i=1 while key i is the accepted held key; all zero otherwise.
key_code  output  4  index+1 of the held key (1..14); 0 when no key is held.
key_press  output  1  one-cycle pulse in the cycle Key first becomes non-zero.
key_release  output  1  one-cycle pulse in the cycle Key returns to zero.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Key=0, key_code=0, key_press=0, key_release=0, busy=0.
  - State=IDLE, counter=0, candidate=0.
  - Both synchroniser stages load the inactive level (all 1s if RAW_ACTIVE_LOW, else all 0s).
  - Reset asserted mid-debounce or mid-hold discards the event; no release pulse is generated.
- Synchroniser:
  - Two flip-flops per bit.
  - Normalised vector p = synchronised value, inverted when RAW_ACTIVE_LOW=1.
  - p reflects key_raw after 2 edges.
- Counter: width clog2(DEBOUNCE_CYCLES); it never wraps because each state leaves at DEBOUNCE_CYCLES-1.
- Priority: sel = lowest set bit of candidate; key_code = sel+1.
- IDLE:
  - p==0: stay.
  - p!=0: candidate<=p, counter<=0, go DEB_PRESS.
- DEB_PRESS:
  - p==0: go IDLE (bounce rejected, no pulse).
  - p!=candidate, p!=0: candidate<=p, counter<=0 (restart).
  - p==candidate, counter<DEBOUNCE_CYCLES-1: counter++.
  - p==candidate, counter==DEBOUNCE_CYCLES-1: go PRESSED; on the same edge Key<=onehot(sel), key_code<=sel+1, key_press<=1.
- PRESSED:
  - p[sel]==1: hold; Key and key_code are stable. Other keys pressed or released are ignored (no rollover, no re-priority).
  - p[sel]==0: counter<=0, go DEB_RELEASE; Key is still held.
- DEB_RELEASE:
  - p[sel]==1: go PRESSED, counter<=0; no pulses.
  - p[sel]==0, counter<DEBOUNCE_CYCLES-1: counter++.
  - p[sel]==0, counter==DEBOUNCE_CYCLES-1: go IDLE; Key<=0, key_code<=0, key_release<=1.
- key_press and key_release are registered, high for exactly one cycle, and never high together.
- Latency:
  - A clean press stable from edge 0 produces Key at edge DEBOUNCE_CYCLES+3.
  - A clean release likewise clears Key at edge DEBOUNCE_CYCLES+3 after the raw release.
- Simultaneous keys: if keys 3 and 9 settle together, key 3 wins. If key 9 is still held when key 3 is released, it is accepted after IDLE plus a fresh full debounce.
- Keys whose index is ≥ N_KEYS do not exist; key_code is always ≤ N_KEYS.

Test Plan (DEBOUNCE_CYCLES=8, RAW_ACTIVE_LOW=1):
1. Reset, then key_raw all 1s for 20 cycles -> Key=0, key_code=0, no pulses, busy=0.
2. Drive key_raw[4]=0 clean from edge 0 -> Key=14'h0010, key_code=5, key_press high for one cycle at edge 11. Release at edge 30 -> Key=0 and key_release pulse at edge 41.
3. Toggle key_raw[2] with 3-cycle glitches 5 times, then hold low -> only one key_press, 11 edges after the last transition; Key=14'h0004.
4. Press keys 3 and 9 (bits 2 and 8) together -> key_code=3.
   - Release bit 2 with bit 8 still held -> key_release for key 3.
   - Then after IDLE plus a fresh debounce, key_code=9 and a new key_press.
5. Hold key 0, then give a 4-cycle release glitch -> Key stays 14'h0001 and no pulses occur.
6. Assert rst_n=0 for 1 cycle while in PRESSED with key 6 -> all outputs 0 immediately and no key_release. The key, still held, is re-accepted at DEBOUNCE_CYCLES+3 edges after rst_n rises.

Source files
------------

// File: rtl/key_scan_debounce.sv
// key_scan_debounce: push-button front end for the segment-display path.
// Synchronises the raw button pins, debounces them as a vector, resolves the
// lowest-index pressed key as the winner and holds it until it is released.
// The outputs are a one-hot key vector, a binary key code (index+1) and
// single-cycle press and release strobes.
module key_scan_debounce #(
  parameter int N_KEYS          = 14,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] Key,
  output logic [3:0]        key_code,
  output logic              key_press,
  output logic              key_release,
  output logic              busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SEL_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] IDLE_LEVEL = {N_KEYS{RAW_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_PRESSED,
    S_DEB_RELEASE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [N_KEYS-1:0] cand;
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] sel_onehot;
  logic [SEL_W-1:0]  sel;
  logic              sel_held;

  // Two-flop synchroniser; reset loads the released level so no phantom
  // press is seen as reset lifts.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving
      // two real flop stages; blocking here would collapse them into one.
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Normalised press vector: bit i is 1 while key i reads as pressed.
  assign press_vec = RAW_ACTIVE_LOW ? ~sync2 : sync2;

  // Lowest set bit of the candidate wins; isolate it as a one-hot mask.
  assign sel_onehot = cand & (~cand + N_KEYS'(1));
  assign sel_held   = |(press_vec & sel_onehot);

  // Binary index of the winning key.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (cand[i]) sel = SEL_W'(i);
    end
  end

  assign busy = (state != S_IDLE);

  // Debounce FSM: accept a press/release only after DEBOUNCE_CYCLES
  // consecutive samples agree; outputs and strobes are registered here.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cand        <= '0;
      Key         <= '0;
      key_code    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (press_vec != '0) begin
            cand  <= press_vec;
            cnt   <= '0;
            state <= S_DEB_PRESS;
          end
        end
        S_DEB_PRESS: begin
          if (press_vec == '0) begin
            state <= S_IDLE;
          end else if (press_vec != cand) begin
            cand <= press_vec;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= S_PRESSED;
            Key       <= sel_onehot;
            key_code  <= 4'(sel) + 4'd1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          // Other keys are ignored while the winner stays down.
          if (!sel_held) begin
            cnt   <= '0;
            state <= S_DEB_RELEASE;
          end
        end
        S_DEB_RELEASE: begin
          if (sel_held) begin
            cnt   <= '0;
            state <= S_PRESSED;
          end else if (cnt == CNT_LAST) begin
            state       <= S_IDLE;
            Key         <= '0;
            key_code    <= '0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Testbench for key_scan_debounce (DEBOUNCE_CYCLES=8, active-low buttons).
// Directed table vectors, hand-written corner sequences, then random button
// activity compared against a run-length reference model.
module tb_key_scan_debounce;

  localparam int N = 14;
  localparam int D = 8;
  localparam logic [N-1:0] ALL_UP = 14'h3FFF;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b0;
  logic [N-1:0] key_raw = ALL_UP;
  logic [N-1:0] Key;
  logic [3:0]   key_code;
  logic         key_press;
  logic         key_release;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;

  key_scan_debounce #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .RAW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .key_raw(key_raw),
    .Key(Key),
    .key_code(key_code),
    .key_press(key_press),
    .key_release(key_release),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a press is accepted once D+1 consecutive identical
  // non-zero samples of the normalised vector arrive while nothing is held;
  // a release is accepted once D+1 consecutive samples show the held key up.
  logic [N-1:0] m_s1, m_s2, m_cand, m_key;
  logic         m_held, m_press, m_rel;
  int           m_run, m_sel, m_code;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = ALL_UP; m_s2 = ALL_UP; m_cand = '0; m_key = '0;
    m_held = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    m_run = 0; m_sel = 0; m_code = 0;
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    logic [N-1:0] p;
    p = ~m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (!m_held) begin
      if (p == '0) m_run = 0;
      else if (m_run > 0 && p == m_cand) m_run++;
      else begin m_cand = p; m_run = 1; end
      if (m_run == D + 1) begin
        m_held = 1'b1; m_run = 0;
        m_sel = lowest(m_cand);
        m_key = '0; m_key[m_sel] = 1'b1;
        m_code = m_sel + 1;
        m_press = 1'b1;
      end
    end else begin
      if (p[m_sel]) m_run = 0;
      else m_run++;
      if (m_run == D + 1) begin
        m_held = 1'b0; m_run = 0;
        m_key = '0; m_code = 0;
        m_rel = 1'b1;
      end
    end
  endtask

  // One clock: the model sees the same inputs as the DUT at the edge, and
  // outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_in);
    if (!rst_n) model_reset();
    else model_step(key_raw);
    #1;
    if (key_press) press_cnt++;
    if (key_release) rel_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [N-1:0] raw;
    int           n;
    logic [N-1:0] key;
    logic [3:0]   code;
    logic         busy;
    logic         press;
    logic         rel;
  } vec_t;

  vec_t vecs[8];
  int   base_p, base_r;

  initial begin
    vecs[0] = '{ALL_UP,   20, 14'h0000, 4'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{14'h3FEF, 10, 14'h0000, 4'd0,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{14'h3FEF,  1, 14'h0010, 4'd5,  1'b1, 1'b1, 1'b0};
    vecs[3] = '{14'h3FEF, 19, 14'h0010, 4'd5,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{ALL_UP,   10, 14'h0010, 4'd5,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{ALL_UP,    1, 14'h0000, 4'd0,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{14'h1FFF, 11, 14'h2000, 4'd14, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{ALL_UP,   11, 14'h0000, 4'd0,  1'b0, 1'b0, 1'b1};

    model_reset();
    ticks(3);
    check("reset_key",  32'(Key), 32'h0);
    check("reset_code", 32'(key_code), 32'h0);
    check("reset_pulses", {30'h0, key_press, key_release}, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Table: idle, key 4 press/release with exact edge timing, key 13.
    press_cnt = 0; rel_cnt = 0;
    for (int v = 0; v < 8; v++) begin
      key_raw = vecs[v].raw;
      ticks(vecs[v].n);
      check($sformatf("vec%0d_key", v),   32'(Key), 32'(vecs[v].key));
      check($sformatf("vec%0d_code", v),  32'(key_code), 32'(vecs[v].code));
      check($sformatf("vec%0d_busy", v),  32'(busy), 32'(vecs[v].busy));
      check($sformatf("vec%0d_press", v), 32'(key_press), 32'(vecs[v].press));
      check($sformatf("vec%0d_rel", v),   32'(key_release), 32'(vecs[v].rel));
    end
    check("vec_press_count", 32'(press_cnt), 32'd2);
    check("vec_rel_count",   32'(rel_cnt),   32'd2);

    // Bouncing key 2: five 3-cycle glitches, then a steady press.
    press_cnt = 0; rel_cnt = 0;
    for (int g = 0; g < 5; g++) begin
      key_raw = 14'h3FFB; ticks(3);
      key_raw = ALL_UP;   ticks(3);
    end
    key_raw = 14'h3FFB;
    ticks(10);
    check("bounce_no_early_key", 32'(Key), 32'h0);
    check("bounce_no_early_press", 32'(press_cnt), 32'd0);
    tick();
    check("bounce_key", 32'(Key), 32'h0004);
    check("bounce_press_once", 32'(press_cnt), 32'd1);
    key_raw = ALL_UP;
    ticks(11);
    check("bounce_release", {31'h0, key_release}, 32'h1);

    // Keys 3 and 9 together: key 3 wins; key 9 follows after a fresh debounce.
    press_cnt = 0; rel_cnt = 0;
    key_raw = 14'h3EFB;
    ticks(11);
    check("simul_code", 32'(key_code), 32'd3);
    check("simul_key", 32'(Key), 32'h0004);
    key_raw = 14'h3EFF;
    ticks(10);
    check("simul_hold_k3", 32'(Key), 32'h0004);
    tick();
    check("simul_rel_k3", {31'h0, key_release}, 32'h1);
    check("simul_rel_key", 32'(Key), 32'h0);
    ticks(8);
    check("simul_k9_pending", 32'(Key), 32'h0);
    check("simul_k9_busy", 32'(busy), 32'h1);
    tick();
    check("simul_k9_code", 32'(key_code), 32'd9);
    check("simul_k9_press", {31'h0, key_press}, 32'h1);
    key_raw = ALL_UP;
    ticks(11);
    check("simul_k9_rel", 32'(rel_cnt), 32'd2);

    // Key 0 held, 4-cycle release glitch must be ignored.
    key_raw = 14'h3FFE;
    ticks(16);
    base_p = press_cnt; base_r = rel_cnt;
    key_raw = ALL_UP;   ticks(4);
    key_raw = 14'h3FFE; ticks(20);
    check("glitch_key", 32'(Key), 32'h0001);
    check("glitch_code", 32'(key_code), 32'd1);
    check("glitch_no_pulses", 32'((press_cnt - base_p) + (rel_cnt - base_r)), 32'd0);
    key_raw = ALL_UP;
    ticks(11);
    check("glitch_final_release", 32'(Key), 32'h0);

    // Reset while key 6 is held: immediate clear, no release, re-accept.
    key_raw = 14'h3FBF;
    ticks(11);
    check("rst_pre_key", 32'(Key), 32'h0040);
    base_r = rel_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_async_key", 32'(Key), 32'h0);
    check("rst_async_code", 32'(key_code), 32'h0);
    check("rst_async_busy", {29'h0, busy, key_press, key_release}, 32'h0);
    tick();
    rst_n = 1'b1;
    ticks(10);
    check("rst_reaccept_early", 32'(Key), 32'h0);
    tick();
    check("rst_reaccept_key", 32'(Key), 32'h0040);
    check("rst_reaccept_press", {31'h0, key_press}, 32'h1);
    check("rst_no_release", 32'(rel_cnt - base_r), 32'd0);
    key_raw = ALL_UP;
    ticks(11);

    // Random button activity against the reference model.
    for (int seg = 0; seg < 300; seg++) begin
      logic [N-1:0] pressed;
      int r;
      int hold;
      r = $urandom_range(0, 9);
      pressed = '0;
      if (r >= 3) pressed[$urandom_range(0, N - 1)] = 1'b1;
      if (r >= 7) pressed[$urandom_range(0, N - 1)] = 1'b1;
      key_raw = ~pressed;
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        tick();
        check("rand_key",   32'(Key), 32'(m_key));
        check("rand_code",  32'(key_code), 32'(m_code));
        check("rand_pulse", {30'h0, key_press, key_release}, {30'h0, m_press, m_rel});
        check("rand_busy",  32'(busy), 32'(m_held || m_run > 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
